// File: rtl/stream_demux_n.sv
// -----------------------------------------------------------------------------
// stream_demux_n
//
// N-way valid/ready stream demultiplexer. Each input beat is steered to the
// channel named by in_sel and parked in that channel's one-entry output
// register. Back-pressure is tracked per channel, so a stalled consumer only
// blocks beats addressed to its own channel.
//
// Parameters:
//   WIDTH     - data bits per beat
//   N_OUT     - number of output channels (2..16)
//   SEL_W     - in_sel width, 2**SEL_W >= N_OUT
//   ZERO_IDLE - 1: an idle lane reads zero; 0: an idle lane shows held data
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   in_valid   - input beat present
//   in_ready   - input beat accepted this cycle (combinational, no in_valid path)
//   in_sel     - destination channel, sampled with in_valid
//   in_data    - input payload
//   out_valid  - bit i: channel i holds a beat
//   out_ready  - bit i: channel i consumer accepts
//   out_data   - lane i = bits [i*WIDTH +: WIDTH]
//   drop_pulse - one-cycle pulse after a beat with in_sel >= N_OUT is discarded
//   drop_count - (only with STREAM_DEMUX_DROP_CNT_EN) saturating 16-bit count
//                of discarded beats
//
// Optional feature macro: STREAM_DEMUX_DROP_CNT_EN
// -----------------------------------------------------------------------------
module stream_demux_n #(
    parameter int WIDTH     = 8,
    parameter int N_OUT     = 3,
    parameter int SEL_W     = 2,
    parameter int ZERO_IDLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [WIDTH-1:0]         in_data,
    output logic [N_OUT-1:0]         out_valid,
    input  logic [N_OUT-1:0]         out_ready,
    output logic [N_OUT*WIDTH-1:0]   out_data,
    output logic                     drop_pulse
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    // Channel count in the same width as a zero-extended select, so the
    // range test below compares like-sized operands.
    localparam logic [SEL_W:0] N_OUT_L = (SEL_W + 1)'(N_OUT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_OUT-1:0]             vld_q;
    logic [N_OUT-1:0]             vld_d;
    logic [N_OUT-1:0][WIDTH-1:0]  dat_q;
    logic [N_OUT-1:0][WIDTH-1:0]  dat_d;
    logic                         drop_q;
    logic                         drop_d;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0]                  drop_cnt_q;
    logic [15:0]                  drop_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Decode and handshake terms
    // ------------------------------------------------------------------
    logic                         sel_ok_s;    // in_sel names a real channel
    logic [N_OUT-1:0]             sel_hit_s;   // one-hot of in_sel (zero if out of range)
    logic [N_OUT-1:0]             room_s;      // channel can take a beat this cycle
    logic                         in_xfer_s;   // input transfer this cycle
    logic [N_OUT-1:0]             load_s;      // per-channel load
    logic [N_OUT-1:0]             drain_s;     // per-channel output transfer

    // Select decode: one-hot channel hit and in-range flag.
    always_comb begin
        sel_ok_s  = ({1'b0, in_sel} < N_OUT_L);
        sel_hit_s = {N_OUT{1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            sel_hit_s[i] = (in_sel == SEL_W'(i));
        end
    end

    // Per-channel room and the resulting input-side ready; out-of-range
    // selects are always accepted so they can be discarded.
    always_comb begin
        room_s   = ~vld_q | out_ready;
        in_ready = sel_ok_s ? (|(sel_hit_s & room_s)) : 1'b1;
    end

    // Transfer qualifiers for the input and each output channel.
    always_comb begin
        in_xfer_s = in_valid & in_ready;
        load_s    = sel_hit_s & {N_OUT{in_xfer_s}};
        drain_s   = vld_q & out_ready;
    end

    // Next-state for each channel register. A load wins over a drain, which
    // covers the drain-and-refill case on a full channel without a bubble.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (load_s[i]) begin
                vld_d[i] = 1'b1;
                dat_d[i] = in_data;
            end else if (drain_s[i]) begin
                vld_d[i] = 1'b0;
                dat_d[i] = dat_q[i];
            end else begin
                vld_d[i] = vld_q[i];
                dat_d[i] = dat_q[i];
            end
        end
    end

    // Discard tracking for out-of-range selects.
    always_comb begin
        drop_d = in_xfer_s & ~sel_ok_s;
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    // Saturating discard counter; steps on the same edge that raises drop_pulse.
    always_comb begin
        if (drop_d) begin
            if (drop_cnt_q == 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q;
            end else begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= {N_OUT{1'b0}};
            dat_q  <= {(N_OUT*WIDTH){1'b0}};
            drop_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            drop_q <= drop_d;
        end
    end

`ifdef STREAM_DEMUX_DROP_CNT_EN
    // Discard counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: all driven from registers; an idle lane is optionally
    // masked to zero so consumers never see stale payload.
    // ------------------------------------------------------------------

    // Output lane assembly from the channel registers.
    always_comb begin
        out_valid = vld_q;
        out_data  = {(N_OUT*WIDTH){1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            if ((ZERO_IDLE != 0) && !vld_q[i]) begin
                out_data[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end else begin
                out_data[i*WIDTH +: WIDTH] = dat_q[i];
            end
        end
    end

    // Discard pulse and optional counter outputs.
    always_comb begin
        drop_pulse = drop_q;
`ifdef STREAM_DEMUX_DROP_CNT_EN
        drop_count = drop_cnt_q;
`endif
    end

endmodule

// File: tb/tb_stream_demux_n.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_n
//
// Directed self-checking bench for stream_demux_n with default parameters
// (WIDTH=8, N_OUT=3, SEL_W=2, ZERO_IDLE=1). Inputs change 1 time unit after
// the rising edge; registered outputs are checked at that point and in_ready
// is checked one further time unit after the inputs settle.
// -----------------------------------------------------------------------------
module tb_stream_demux_n;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [23:0] out_data;
    logic        drop_pulse;
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int checks;
    int failures;

    stream_demux_n #(
        .WIDTH(8),
        .N_OUT(3),
        .SEL_W(2),
        .ZERO_IDLE(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sel(in_sel),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .drop_pulse(drop_pulse)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs and let combinational outputs settle.
    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [2:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        out_ready = 3'b000;

        // Reset for two cycles.
        tick();
        tick();
        rst = 1'b0;
        check("reset_out_valid", {29'd0, out_valid}, 32'h0);
        check("reset_out_data", {8'd0, out_data}, 32'h0);
        check("reset_drop_pulse", {31'd0, drop_pulse}, 32'h0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("reset_drop_count", {16'd0, drop_count}, 32'h0);
`endif

        // Route A5 to channel 1.
        drive(1'b1, 2'd1, 8'hA5, 3'b111);
        check("route_in_ready", {31'd0, in_ready}, 32'h1);
        tick();
        drive(1'b0, 2'd0, 8'h00, 3'b111);
        check("route_out_valid", {29'd0, out_valid}, 32'h2);
        check("route_out_data", {8'd0, out_data}, 32'h00A500);
        tick();
        check("route_drained", {29'd0, out_valid}, 32'h0);

        // Stall isolation: channel 0 blocked.
        drive(1'b1, 2'd0, 8'h11, 3'b110);
        check("stall_first_ready", {31'd0, in_ready}, 32'h1);
        tick();
        drive(1'b1, 2'd0, 8'h22, 3'b110);
        check("stall_second_not_ready", {31'd0, in_ready}, 32'h0);
        tick();
        check("stall_ch0_valid", {29'd0, out_valid}, 32'h1);
        check("stall_ch0_data", {8'd0, out_data}, 32'h000011);
        drive(1'b1, 2'd2, 8'h33, 3'b110);
        check("stall_other_ready", {31'd0, in_ready}, 32'h1);
        tick();
        check("stall_both_valid", {29'd0, out_valid}, 32'h5);
        check("stall_both_data", {8'd0, out_data}, 32'h330011);
        drive(1'b1, 2'd0, 8'h22, 3'b111);
        check("release_ready", {31'd0, in_ready}, 32'h1);
        tick();
        drive(1'b0, 2'd0, 8'h00, 3'b111);
        check("release_second_valid", {29'd0, out_valid}, 32'h1);
        check("release_second_data", {8'd0, out_data}, 32'h000022);
        tick();
        check("release_empty", {29'd0, out_valid}, 32'h0);

        // Full throughput: 16 back-to-back beats to channel 2.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 2'd2, 8'(k), 3'b111);
            check("stream_in_ready", {31'd0, in_ready}, 32'h1);
            tick();
            check("stream_out_valid", {29'd0, out_valid}, 32'h4);
            check("stream_out_data", {8'd0, out_data}, {8'd0, 8'(k), 16'h0000});
        end
        drive(1'b0, 2'd0, 8'h00, 3'b111);
        tick();
        check("stream_end_empty", {29'd0, out_valid}, 32'h0);

        // Simultaneous drain and load on channel 1.
        drive(1'b1, 2'd1, 8'h44, 3'b101);
        tick();
        drive(1'b0, 2'd0, 8'h00, 3'b101);
        check("dl_full_valid", {29'd0, out_valid}, 32'h2);
        check("dl_full_data", {8'd0, out_data}, 32'h004400);
        drive(1'b1, 2'd1, 8'h55, 3'b111);
        check("dl_in_ready", {31'd0, in_ready}, 32'h1);
        tick();
        drive(1'b0, 2'd0, 8'h00, 3'b111);
        check("dl_refill_valid", {29'd0, out_valid}, 32'h2);
        check("dl_refill_data", {8'd0, out_data}, 32'h005500);
        tick();
        check("dl_empty", {29'd0, out_valid}, 32'h0);

        // Invalid select with channel 0 stalled holding 77.
        drive(1'b1, 2'd0, 8'h77, 3'b000);
        tick();
        drive(1'b1, 2'd3, 8'hEE, 3'b000);
        check("inv_in_ready", {31'd0, in_ready}, 32'h1);
        check("inv_no_pulse_yet", {31'd0, drop_pulse}, 32'h0);
        tick();
        check("inv_pulse1", {31'd0, drop_pulse}, 32'h1);
        check("inv_valid1", {29'd0, out_valid}, 32'h1);
        check("inv_data1", {8'd0, out_data}, 32'h000077);
        tick();
        check("inv_pulse2", {31'd0, drop_pulse}, 32'h1);
        tick();
        drive(1'b0, 2'd0, 8'h00, 3'b000);
        check("inv_pulse3", {31'd0, drop_pulse}, 32'h1);
        check("inv_valid3", {29'd0, out_valid}, 32'h1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("inv_drop_count", {16'd0, drop_count}, 32'h3);
`endif
        tick();
        check("inv_pulse_end", {31'd0, drop_pulse}, 32'h0);

        // Reset mid-flight with channels 0 and 2 full.
        drive(1'b1, 2'd2, 8'h99, 3'b000);
        tick();
        drive(1'b0, 2'd0, 8'h00, 3'b000);
        check("mid_full_valid", {29'd0, out_valid}, 32'h5);
        check("mid_full_data", {8'd0, out_data}, 32'h990077);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", {29'd0, out_valid}, 32'h0);
        check("mid_rst_data", {8'd0, out_data}, 32'h0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        check("mid_rst_drop_count", {16'd0, drop_count}, 32'h0);
`endif
        tick();
        check("post_rst_hold", {29'd0, out_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
